// File: rtl/afifo_pkg.sv
// Shared types and pointer-coding helpers for the asynchronous FIFO.
// Used by both the read-side and write-side pointer blocks.
// The Gray helpers work on a wide vector. A narrower pointer is zero-extended
// on the way in and truncated on the way out. Gray and binary coding both
// leave zero-extension intact, so the result is exact for any width up to
// AFIFO_PTR_MAX_W.
package afifo_pkg;

  localparam int AFIFO_ADDRSIZE  = 4;
  localparam int AFIFO_PTR_MAX_W = 16;

  typedef logic [AFIFO_ADDRSIZE:0]    afifo_ptr_t;
  typedef logic [AFIFO_PTR_MAX_W-1:0] afifo_wide_t;

  function automatic afifo_wide_t bin2gray(input afifo_wide_t bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic afifo_wide_t gray2bin(input afifo_wide_t gray);
    afifo_wide_t bin;
    for (int i = 0; i < AFIFO_PTR_MAX_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/afifo_gray2bin.sv
// Combinational Gray-to-binary decoder.
// Each binary bit is the XOR of all Gray bits at or above its position.
module afifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // A reduction per bit, so no bit-to-bit combinational chain
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^(gray_i >> i);
  end

endmodule

// File: rtl/afifo_rptr_status.sv
// Read-domain pointer and status controller for the asynchronous FIFO.
// It owns the read pointer and produces registered empty, almost-empty and
// read-side level from the synchronised write pointer.
// Optional feature: AFIFO_RD_UNDERFLOW_EN enables the sticky underflow flag.
// When it is undefined, underflow_o is tied low and no flop is built.
module afifo_rptr_status
  import afifo_pkg::*;
#(
  parameter int ADDRSIZE = AFIFO_ADDRSIZE
) (
  input  logic                rclk_i,
  input  logic                rrst_n_i,
  input  logic                ren_i,
  input  logic [ADDRSIZE:0]   wptr_gray_sync_i,
  input  logic [ADDRSIZE:0]   ae_thresh_i,
  input  logic                underflow_clr_i,
  output logic                rd_en_o,
  output logic [ADDRSIZE-1:0] rd_addr_o,
  output logic [ADDRSIZE:0]   rptr_gray_o,
  output logic                fifo_empty_o,
  output logic                fifo_almost_empty_o,
  output logic [ADDRSIZE:0]   rd_level_o,
  output logic                underflow_o
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin_sync;
  logic          accept;
  logic [PW-1:0] rbin_q,  rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          aempty_q, aempty_d;

  afifo_gray2bin #(.W(PW)) u_wptr_g2b (
    .gray_i (wptr_gray_sync_i),
    .bin_o  (wbin_sync)
  );

  assign accept = ren_i & ~empty_q;

  // Next pointer and status. Status is computed from the post-read pointer,
  // so a read on this edge is already reflected in the flags.
  always_comb begin
    rbin_d   = rbin_q + PW'(accept);
    rgray_d  = PW'(bin2gray(afifo_wide_t'(rbin_d)));
    level_d  = wbin_sync - rbin_d;
    empty_d  = (rgray_d == wptr_gray_sync_i);
    aempty_d = (level_d <= ae_thresh_i);
  end

  // Pointer and status registers; the FIFO reads empty out of reset
  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
    end
  end

`ifdef AFIFO_RD_UNDERFLOW_EN
  logic underflow_q, underflow_d;

  // Sticky underflow; a new underflow wins over a coincident clear
  always_comb begin
    underflow_d = underflow_q;
    if (underflow_clr_i) underflow_d = 1'b0;
    if (ren_i & empty_q) underflow_d = 1'b1;
  end

  // Underflow flag register
  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) underflow_q <= 1'b0;
    else           underflow_q <= underflow_d;
  end

  assign underflow_o = underflow_q;
`else
  logic unused_underflow_clr;
  assign unused_underflow_clr = underflow_clr_i;
  assign underflow_o          = 1'b0;
`endif

  assign rd_en_o             = accept;
  assign rd_addr_o           = rbin_q[ADDRSIZE-1:0];
  assign rptr_gray_o         = rgray_q;
  assign fifo_empty_o        = empty_q;
  assign fifo_almost_empty_o = aempty_q;
  assign rd_level_o          = level_q;

endmodule

// File: tb/tb_afifo_rptr_status.sv
// Directed bench for afifo_rptr_status with ADDRSIZE=3 (4-bit pointers).
// The underflow expectations follow whether AFIFO_RD_UNDERFLOW_EN is defined.
module tb_afifo_rptr_status;

  localparam int AS = 3;
`ifdef AFIFO_RD_UNDERFLOW_EN
  localparam logic UF_EN = 1'b1;
`else
  localparam logic UF_EN = 1'b0;
`endif

  logic          rclk_i = 1'b0;
  logic          rrst_n_i;
  logic          ren_i;
  logic [AS:0]   wptr_gray_sync_i;
  logic [AS:0]   ae_thresh_i;
  logic          underflow_clr_i;
  logic          rd_en_o;
  logic [AS-1:0] rd_addr_o;
  logic [AS:0]   rptr_gray_o;
  logic          fifo_empty_o;
  logic          fifo_almost_empty_o;
  logic [AS:0]   rd_level_o;
  logic          underflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  afifo_rptr_status #(.ADDRSIZE(AS)) dut (
    .rclk_i              (rclk_i),
    .rrst_n_i            (rrst_n_i),
    .ren_i               (ren_i),
    .wptr_gray_sync_i    (wptr_gray_sync_i),
    .ae_thresh_i         (ae_thresh_i),
    .underflow_clr_i     (underflow_clr_i),
    .rd_en_o             (rd_en_o),
    .rd_addr_o           (rd_addr_o),
    .rptr_gray_o         (rptr_gray_o),
    .fifo_empty_o        (fifo_empty_o),
    .fifo_almost_empty_o (fifo_almost_empty_o),
    .rd_level_o          (rd_level_o),
    .underflow_o         (underflow_o)
  );

  always #5 rclk_i = ~rclk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk_i);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " empty"}, 32'(fifo_empty_o), 32'd1);
    check({tag, " aempty"}, 32'(fifo_almost_empty_o), 32'd1);
    check({tag, " level"}, 32'(rd_level_o), 32'd0);
    check({tag, " addr"}, 32'(rd_addr_o), 32'd0);
    check({tag, " gray"}, 32'(rptr_gray_o), 32'd0);
    check({tag, " uf"}, 32'(underflow_o), 32'd0);
    check({tag, " rd_en"}, 32'(rd_en_o), 32'd0);
  endtask

  initial begin
    rrst_n_i         = 1'b0;
    ren_i            = 1'b0;
    wptr_gray_sync_i = '0;
    ae_thresh_i      = '0;
    underflow_clr_i  = 1'b0;

    // reset held
    step();
    step();
    check_reset_vals("rst");
    ren_i = 1'b1;
    #1;
    check("rst ren rd_en", 32'(rd_en_o), 32'd0);
    ren_i = 1'b0;
    step();
    rrst_n_i = 1'b1;

    // level and threshold
    wptr_gray_sync_i = 4'b0011;
    ae_thresh_i      = 4'd2;
    step();
    check("lvl empty", 32'(fifo_empty_o), 32'd0);
    check("lvl level", 32'(rd_level_o), 32'd2);
    check("lvl ae th2", 32'(fifo_almost_empty_o), 32'd1);
    ae_thresh_i = 4'd1;
    step();
    check("lvl ae th1", 32'(fifo_almost_empty_o), 32'd0);

    // drain three words with four requests
    wptr_gray_sync_i = 4'b0010;
    step();
    check("drain level0", 32'(rd_level_o), 32'd3);
    ren_i = 1'b1;
    #1;
    check("drain rd_en0", 32'(rd_en_o), 32'd1);
    check("drain addr0", 32'(rd_addr_o), 32'd0);
    step();
    check("drain addr1", 32'(rd_addr_o), 32'd1);
    check("drain level1", 32'(rd_level_o), 32'd2);
    check("drain gray1", 32'(rptr_gray_o), 32'b0001);
    check("drain rd_en1", 32'(rd_en_o), 32'd1);
    step();
    check("drain addr2", 32'(rd_addr_o), 32'd2);
    check("drain level2", 32'(rd_level_o), 32'd1);
    check("drain ae2", 32'(fifo_almost_empty_o), 32'd1);
    check("drain rd_en2", 32'(rd_en_o), 32'd1);
    step();
    check("drain addr3", 32'(rd_addr_o), 32'd3);
    check("drain level3", 32'(rd_level_o), 32'd0);
    check("drain empty3", 32'(fifo_empty_o), 32'd1);
    check("drain gray3", 32'(rptr_gray_o), 32'b0010);
    check("drain rd_en3", 32'(rd_en_o), 32'd0);
    step();
    check("drain addr4", 32'(rd_addr_o), 32'd3);
    check("drain level4", 32'(rd_level_o), 32'd0);
    check("drain uf4", 32'(underflow_o), 32'(UF_EN));
    ren_i           = 1'b0;
    underflow_clr_i = 1'b1;
    step();
    underflow_clr_i = 1'b0;
    check("drain uf clr", 32'(underflow_o), 32'd0);

    // full FIFO: wptr bin 11, rbin 3 -> level 8
    wptr_gray_sync_i = 4'b1110;
    step();
    check("full level", 32'(rd_level_o), 32'd8);
    check("full empty", 32'(fifo_empty_o), 32'd0);
    check("full ae", 32'(fifo_almost_empty_o), 32'd0);
    ae_thresh_i = 4'd9;
    step();
    check("full ae th9", 32'(fifo_almost_empty_o), 32'd1);
    ae_thresh_i = 4'd1;
    ren_i       = 1'b1;
    for (int i = 0; i < 8; i++) step();
    ren_i = 1'b0;
    check("full drained addr", 32'(rd_addr_o), 32'd3);
    check("full drained gray", 32'(rptr_gray_o), 32'b1110);
    check("full drained empty", 32'(fifo_empty_o), 32'd1);
    check("full drained level", 32'(rd_level_o), 32'd0);

    // advance to bin 15 with threshold 0
    wptr_gray_sync_i = 4'b1000;
    step();
    check("adv level", 32'(rd_level_o), 32'd4);
    ae_thresh_i = 4'd0;
    step();
    check("adv ae th0", 32'(fifo_almost_empty_o), 32'd0);
    ren_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ren_i = 1'b0;
    check("adv gray", 32'(rptr_gray_o), 32'b1000);
    check("adv addr", 32'(rd_addr_o), 32'd7);
    check("adv empty", 32'(fifo_empty_o), 32'd1);
    check("adv ae th0 empty", 32'(fifo_almost_empty_o), 32'd1);
    ae_thresh_i = 4'd1;

    // wrap: wptr bin 1
    wptr_gray_sync_i = 4'b0001;
    step();
    check("wrap level0", 32'(rd_level_o), 32'd2);
    check("wrap empty0", 32'(fifo_empty_o), 32'd0);
    check("wrap addr0", 32'(rd_addr_o), 32'd7);
    ren_i = 1'b1;
    step();
    check("wrap gray1", 32'(rptr_gray_o), 32'b0000);
    check("wrap addr1", 32'(rd_addr_o), 32'd0);
    check("wrap level1", 32'(rd_level_o), 32'd1);
    check("wrap empty1", 32'(fifo_empty_o), 32'd0);
    step();
    ren_i = 1'b0;
    check("wrap gray2", 32'(rptr_gray_o), 32'b0001);
    check("wrap addr2", 32'(rd_addr_o), 32'd1);
    check("wrap level2", 32'(rd_level_o), 32'd0);
    check("wrap empty2", 32'(fifo_empty_o), 32'd1);

    // underflow set / clear / set-beats-clear
    ren_i = 1'b1;
    step();
    check("uf set", 32'(underflow_o), 32'(UF_EN));
    check("uf addr", 32'(rd_addr_o), 32'd1);
    ren_i           = 1'b0;
    underflow_clr_i = 1'b1;
    step();
    check("uf clr", 32'(underflow_o), 32'd0);
    ren_i = 1'b1;
    step();
    check("uf set+clr", 32'(underflow_o), 32'(UF_EN));
    ren_i           = 1'b0;
    underflow_clr_i = 1'b0;
    step();
    check("uf hold", 32'(underflow_o), 32'(UF_EN));
    underflow_clr_i = 1'b1;
    step();
    underflow_clr_i = 1'b0;
    check("uf clr2", 32'(underflow_o), 32'd0);

    // mid-operation async reset, level 5 (wptr bin 6, rbin 1)
    wptr_gray_sync_i = 4'b0101;
    step();
    check("mid level", 32'(rd_level_o), 32'd5);
    #2;
    rrst_n_i = 1'b0;
    #1;
    check_reset_vals("mid rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
